// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage F/D/E/M/W pipeline.
// It produces stall/flush enables for the pipeline registers and E-stage
// forwarding selects. It sequences load-use stalls, taken-branch flushes and
// multi-cycle execute waits, and counts stall and branch-flush cycles.
// Control outputs are Mealy in RUN, so they are combinational. They are gated
// by rst_n so that they drop the moment reset is asserted.

module hazard_ctrl #(
  parameter int LOAD_LAT   = 1,
  parameter int BR_PENALTY = 1,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       regSrcA_D,
  input  logic [3:0]       regSrcB_D,
  input  logic             useA_D,
  input  logic             useB_D,
  input  logic [3:0]       regSrcA_E,
  input  logic [3:0]       regSrcB_E,
  input  logic [3:0]       regScr_E,
  input  logic             regw_E,
  input  logic             regmem_E,
  input  logic [3:0]       regScr_M,
  input  logic             regw_M,
  input  logic [3:0]       regScr_W,
  input  logic             regw_W,
  input  logic             branch_taken_E,
  input  logic             mc_start_E,
  input  logic             mc_done,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The sequence counter must hold MC_TIMEOUT-1 as well as LOAD_LAT-1 and
  // BR_PENALTY-1. Those two are at most 6, so 3 bits is the floor.
  localparam int SEQ_W = ($clog2(MC_TIMEOUT) > 3) ? $clog2(MC_TIMEOUT) : 3;
  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    BRFLUSH = 2'b10,
    MCWAIT  = 2'b11
  } state_t;

  // A source matches a producer only if the source is actually read, the
  // producer writes, and the register is not the PC.
  function automatic logic reg_hit(input logic [3:0] src, input logic used,
                                   input logic [3:0] dst, input logic wr);
    return used & wr & (dst != PC_REG) & (src == dst);
  endfunction

  // Forwarding select for one E-stage operand. The younger M result wins over W.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src,
                                         input logic [3:0] dst_m, input logic wr_m,
                                         input logic [3:0] dst_w, input logic wr_w);
    logic [1:0] sel;
    if (reg_hit(src, 1'b1, dst_m, wr_m)) begin
      sel = 2'b10;
    end else if (reg_hit(src, 1'b1, dst_w, wr_w)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Saturating increment for the event counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic en);
    logic [CNT_W-1:0] res;
    if (en && (val != {CNT_W{1'b1}})) begin
      res = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

  state_t            r_state;
  logic [SEQ_W-1:0]  r_cnt;
  logic              r_mc_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_load_use;
  logic              w_stall_F;
  logic              w_stall_D;
  logic              w_stall_E;
  logic              w_flush_D;
  logic              w_flush_E;
  logic              w_flush_M;
  logic              w_br_flush;
  logic [1:0]        w_fwdA;
  logic [1:0]        w_fwdB;

  // Load-use hazard detection and the operand forwarding selects.
  always_comb begin
    w_load_use = regmem_E & regw_E &
                 (reg_hit(regSrcA_D, useA_D, regScr_E, regw_E) |
                  reg_hit(regSrcB_D, useB_D, regScr_E, regw_E));
    w_fwdA     = fwd_sel(regSrcA_E, regScr_M, regw_M, regScr_W, regw_W);
    w_fwdB     = fwd_sel(regSrcB_E, regScr_M, regw_M, regScr_W, regw_W);
  end

  // Stall/flush decode: Mealy in RUN, Moore in the sequencing states.
  always_comb begin
    w_stall_F  = 1'b0;
    w_stall_D  = 1'b0;
    w_stall_E  = 1'b0;
    w_flush_D  = 1'b0;
    w_flush_E  = 1'b0;
    w_flush_M  = 1'b0;
    w_br_flush = 1'b0;
    case (r_state)
      RUN: begin
        if (branch_taken_E) begin
          // The D instruction is squashed, so a coincident load-use is moot.
          w_flush_D  = 1'b1;
          w_flush_E  = 1'b1;
          w_br_flush = 1'b1;
        end else if (mc_start_E) begin
          w_stall_F = 1'b0;
        end else if (w_load_use) begin
          w_stall_F = 1'b1;
          w_stall_D = 1'b1;
          w_flush_E = 1'b1;
        end else begin
          w_stall_F = 1'b0;
        end
      end
      LDSTALL: begin
        w_stall_F = 1'b1;
        w_stall_D = 1'b1;
        w_flush_E = 1'b1;
      end
      BRFLUSH: begin
        w_flush_D = 1'b1;
      end
      MCWAIT: begin
        w_stall_F = 1'b1;
        w_stall_D = 1'b1;
        w_stall_E = 1'b1;
        w_flush_M = 1'b1;
      end
      default: begin
        w_stall_F = 1'b0;
      end
    endcase
  end

  // Sequencer: state, remaining-cycle/age counter and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_cnt    <= {SEQ_W{1'b0}};
      r_mc_err <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (branch_taken_E) begin
            if (BR_PENALTY > 1) begin
              r_state <= BRFLUSH;
              r_cnt   <= SEQ_W'(BR_PENALTY - 1);
            end else begin
              r_state <= RUN;
            end
          end else if (mc_start_E) begin
            r_state <= MCWAIT;
            r_cnt   <= {SEQ_W{1'b0}};
          end else if (w_load_use) begin
            if (LOAD_LAT > 1) begin
              r_state <= LDSTALL;
              r_cnt   <= SEQ_W'(LOAD_LAT - 1);
            end else begin
              r_state <= RUN;
            end
          end else begin
            r_state <= RUN;
          end
        end
        LDSTALL, BRFLUSH: begin
          // Both count down the cycles still owed and then resume.
          if (r_cnt <= SEQ_W'(1)) begin
            r_state <= RUN;
            r_cnt   <= {SEQ_W{1'b0}};
          end else begin
            r_cnt   <= r_cnt - {{(SEQ_W-1){1'b0}}, 1'b1};
          end
        end
        MCWAIT: begin
          // Completion takes precedence over a timeout in the same cycle.
          if (mc_done) begin
            r_state <= RUN;
            r_cnt   <= {SEQ_W{1'b0}};
          end else if (r_cnt == SEQ_W'(MC_TIMEOUT - 1)) begin
            r_state  <= RUN;
            r_cnt    <= {SEQ_W{1'b0}};
            r_mc_err <= 1'b1;
          end else begin
            r_cnt    <= r_cnt + {{(SEQ_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= {SEQ_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating event counters: stall cycles and branch-induced E flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      r_stall_cnt <= sat_inc(r_stall_cnt, w_stall_D);
      r_flush_cnt <= sat_inc(r_flush_cnt, w_br_flush);
    end
  end

  assign stall_F   = rst_n & w_stall_F;
  assign stall_D   = rst_n & w_stall_D;
  assign stall_E   = rst_n & w_stall_E;
  assign flush_D   = rst_n & w_flush_D;
  assign flush_E   = rst_n & w_flush_E;
  assign flush_M   = rst_n & w_flush_M;
  assign fwdA_E    = {2{rst_n}} & w_fwdA;
  assign fwdB_E    = {2{rst_n}} & w_fwdB;
  assign mc_err    = r_mc_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two hazard_ctrl instances share one set of inputs.
// Instance A uses LOAD_LAT=1, BR_PENALTY=1 and 16-bit counters.
// Instance B uses LOAD_LAT=3, BR_PENALTY=3 and 4-bit counters, so counter
// saturation shows up. Both instances use MC_TIMEOUT=8.

module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] regSrcA_D, regSrcB_D, regSrcA_E, regSrcB_E, regScr_E, regScr_M, regScr_W;
  logic useA_D, useB_D, regw_E, regmem_E, regw_M, regw_W;
  logic branch_taken_E, mc_start_E, mc_done;

  logic a_stall_F, a_stall_D, a_stall_E, a_flush_D, a_flush_E, a_flush_M, a_mc_err;
  logic b_stall_F, b_stall_D, b_stall_E, b_flush_D, b_flush_E, b_flush_M, b_mc_err;
  logic [1:0] a_fwdA, a_fwdB, b_fwdA, b_fwdB;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic [3:0]  b_stall_cnt, b_flush_cnt;
  logic [5:0]  a_ctl, b_ctl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .BR_PENALTY(1), .MC_TIMEOUT(8), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .regSrcA_D(regSrcA_D), .regSrcB_D(regSrcB_D),
    .useA_D(useA_D), .useB_D(useB_D), .regSrcA_E(regSrcA_E), .regSrcB_E(regSrcB_E),
    .regScr_E(regScr_E), .regw_E(regw_E), .regmem_E(regmem_E), .regScr_M(regScr_M),
    .regw_M(regw_M), .regScr_W(regScr_W), .regw_W(regw_W),
    .branch_taken_E(branch_taken_E), .mc_start_E(mc_start_E), .mc_done(mc_done),
    .stall_F(a_stall_F), .stall_D(a_stall_D), .stall_E(a_stall_E),
    .flush_D(a_flush_D), .flush_E(a_flush_E), .flush_M(a_flush_M),
    .fwdA_E(a_fwdA), .fwdB_E(a_fwdB), .mc_err(a_mc_err),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  hazard_ctrl #(.LOAD_LAT(3), .BR_PENALTY(3), .MC_TIMEOUT(8), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .regSrcA_D(regSrcA_D), .regSrcB_D(regSrcB_D),
    .useA_D(useA_D), .useB_D(useB_D), .regSrcA_E(regSrcA_E), .regSrcB_E(regSrcB_E),
    .regScr_E(regScr_E), .regw_E(regw_E), .regmem_E(regmem_E), .regScr_M(regScr_M),
    .regw_M(regw_M), .regScr_W(regScr_W), .regw_W(regw_W),
    .branch_taken_E(branch_taken_E), .mc_start_E(mc_start_E), .mc_done(mc_done),
    .stall_F(b_stall_F), .stall_D(b_stall_D), .stall_E(b_stall_E),
    .flush_D(b_flush_D), .flush_E(b_flush_E), .flush_M(b_flush_M),
    .fwdA_E(b_fwdA), .fwdB_E(b_fwdB), .mc_err(b_mc_err),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  // Control bits, in order: stall_F stall_D stall_E flush_D flush_E flush_M.
  assign a_ctl = {a_stall_F, a_stall_D, a_stall_E, a_flush_D, a_flush_E, a_flush_M};
  assign b_ctl = {b_stall_F, b_stall_D, b_stall_E, b_flush_D, b_flush_E, b_flush_M};

  // Reference model state, one slot per instance. The model tracks how many
  // cycles are still owed and the age of a multi-cycle wait.
  int p_ll[2]  = '{1, 3};
  int p_bp[2]  = '{1, 3};
  int p_max[2] = '{65535, 15};
  int p_mt     = 8;
  int m_ld[2], m_br[2], m_age[2], m_sc[2], m_fc[2];
  bit m_mc[2], m_err[2];

  task automatic idle_inputs();
    regSrcA_D = 4'd0; regSrcB_D = 4'd0; useA_D = 1'b0; useB_D = 1'b0;
    regSrcA_E = 4'd0; regSrcB_E = 4'd0; regScr_E = 4'd0; regw_E = 1'b0;
    regmem_E = 1'b0; regScr_M = 4'd0; regw_M = 1'b0; regScr_W = 4'd0;
    regw_W = 1'b0; branch_taken_E = 1'b0; mc_start_E = 1'b0; mc_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] rreg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 4'd15 : 4'(r);
  endfunction

  function automatic int ref_fwd(input logic [3:0] src);
    if (regw_M && regScr_M != 4'd15 && regScr_M == src) return 2;
    if (regw_W && regScr_W != 4'd15 && regScr_W == src) return 1;
    return 0;
  endfunction

  task automatic test_reset();
    idle_inputs();
    regw_M = 1'b1; regScr_M = 4'd4; regSrcA_E = 4'd4;
    regmem_E = 1'b1; regw_E = 1'b1; regScr_E = 4'd2; regSrcA_D = 4'd2; useA_D = 1'b1;
    #1;
    total++;
    if ({a_ctl, b_ctl, a_fwdA, b_fwdA} !== 16'd0) begin
      bad++; $display("FAIL reset_held_outputs got=%h exp=0", {a_ctl, b_ctl, a_fwdA, b_fwdA});
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ({a_ctl, b_ctl, a_fwdA, a_fwdB, b_fwdA, b_fwdB, a_mc_err, b_mc_err} !== 22'd0) begin
        bad++; $display("FAIL reset_idle_outputs cyc=%0d got=%h exp=0", i,
                        {a_ctl, b_ctl, a_fwdA, a_fwdB, b_fwdA, b_fwdB, a_mc_err, b_mc_err});
      end
      total++;
      if ({a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt} !== 40'd0) begin
        bad++; $display("FAIL reset_counters cyc=%0d got=%h exp=0", i,
                        {a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    regmem_E = 1'b1; regw_E = 1'b1; regScr_E = 4'd3; regSrcA_D = 4'd3; useA_D = 1'b1;
    #1;
    total++;
    if ({a_ctl, b_ctl} !== {6'b110010, 6'b110010}) begin
      bad++; $display("FAIL lu_first got=%b exp=%b", {a_ctl, b_ctl}, {6'b110010, 6'b110010});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if ({a_ctl, b_ctl} !== {6'b000000, 6'b110010}) begin
      bad++; $display("FAIL lu_second got=%b exp=%b", {a_ctl, b_ctl}, {6'b000000, 6'b110010});
    end
    total++;
    if (a_stall_cnt !== 16'd1) begin
      bad++; $display("FAIL lu_a_stall_cnt got=%0d exp=1", a_stall_cnt);
    end
    @(negedge clk);
    #1;
    total++;
    if (b_ctl !== 6'b110010) begin
      bad++; $display("FAIL lu_b_third got=%b exp=110010", b_ctl);
    end
    @(negedge clk);
    #1;
    total++;
    if ({b_ctl, b_stall_cnt} !== {6'b000000, 4'd3}) begin
      bad++; $display("FAIL lu_b_done got=%b/%0d exp=000000/3", b_ctl, b_stall_cnt);
    end
    // A load with its write flag clear is not a producer.
    regmem_E = 1'b1; regw_E = 1'b0; regScr_E = 4'd3; regSrcA_D = 4'd3; useA_D = 1'b1;
    #1;
    total++;
    if ({a_ctl, b_ctl} !== 12'd0) begin
      bad++; $display("FAIL lu_no_write got=%b exp=0", {a_ctl, b_ctl});
    end
    @(negedge clk);
    regw_E = 1'b1; regScr_E = 4'd15; regSrcA_D = 4'd15;
    #1;
    total++;
    if ({a_ctl, b_ctl} !== 12'd0) begin
      bad++; $display("FAIL lu_pc_reg got=%b exp=0", {a_ctl, b_ctl});
    end
    @(negedge clk);
    regScr_E = 4'd5; regSrcA_D = 4'd5; useA_D = 1'b0; regSrcB_D = 4'd5; useB_D = 1'b0;
    #1;
    total++;
    if ({a_ctl, a_stall_cnt} !== {6'd0, 16'd1}) begin
      bad++; $display("FAIL lu_unused_src got=%b/%0d exp=0/1", a_ctl, a_stall_cnt);
    end
    @(negedge clk);
    useB_D = 1'b1;
    #1;
    total++;
    if (a_ctl !== 6'b110010) begin
      bad++; $display("FAIL lu_src_b got=%b exp=110010", a_ctl);
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_branch_vs_load();
    do_reset();
    regmem_E = 1'b1; regw_E = 1'b1; regScr_E = 4'd3; regSrcA_D = 4'd3; useA_D = 1'b1;
    branch_taken_E = 1'b1;
    #1;
    total++;
    if ({a_ctl, b_ctl} !== {6'b000110, 6'b000110}) begin
      bad++; $display("FAIL br_first got=%b exp=%b", {a_ctl, b_ctl}, {6'b000110, 6'b000110});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if ({a_ctl, a_flush_cnt, a_stall_cnt} !== {6'd0, 16'd1, 16'd0}) begin
      bad++; $display("FAIL br_a_after got=%b/%0d/%0d exp=0/1/0", a_ctl, a_flush_cnt, a_stall_cnt);
    end
    total++;
    if (b_ctl !== 6'b000100) begin
      bad++; $display("FAIL br_b_hold1 got=%b exp=000100", b_ctl);
    end
    @(negedge clk);
    #1;
    total++;
    if (b_ctl !== 6'b000100) begin
      bad++; $display("FAIL br_b_hold2 got=%b exp=000100", b_ctl);
    end
    @(negedge clk);
    #1;
    total++;
    if ({b_ctl, b_flush_cnt, b_stall_cnt} !== {6'd0, 4'd1, 4'd0}) begin
      bad++; $display("FAIL br_b_done got=%b/%0d/%0d exp=0/1/0", b_ctl, b_flush_cnt, b_stall_cnt);
    end
  endtask

  task automatic test_forwarding();
    idle_inputs();
    regw_M = 1'b1; regScr_M = 4'd4; regw_W = 1'b1; regScr_W = 4'd4;
    regSrcA_E = 4'd4; regSrcB_E = 4'd9;
    #1;
    total++;
    if ({a_fwdA, a_fwdB, b_fwdA} !== 6'b10_00_10) begin
      bad++; $display("FAIL fwd_m_priority got=%b exp=100010", {a_fwdA, a_fwdB, b_fwdA});
    end
    regw_M = 1'b0;
    #1;
    total++;
    if ({a_fwdA, b_fwdA} !== 4'b01_01) begin
      bad++; $display("FAIL fwd_from_w got=%b exp=0101", {a_fwdA, b_fwdA});
    end
    regScr_W = 4'd9;
    #1;
    total++;
    if ({a_fwdA, a_fwdB} !== 4'b00_01) begin
      bad++; $display("FAIL fwd_b_from_w got=%b exp=0001", {a_fwdA, a_fwdB});
    end
    regw_M = 1'b1; regScr_M = 4'd9;
    #1;
    total++;
    if ({a_fwdB, b_fwdB} !== 4'b10_10) begin
      bad++; $display("FAIL fwd_b_from_m got=%b exp=1010", {a_fwdB, b_fwdB});
    end
    regScr_M = 4'd15; regScr_W = 4'd15; regSrcA_E = 4'd15; regSrcB_E = 4'd15;
    #1;
    total++;
    if ({a_fwdA, a_fwdB} !== 4'b0000) begin
      bad++; $display("FAIL fwd_pc_reg got=%b exp=0000", {a_fwdA, a_fwdB});
    end
    idle_inputs();
  endtask

  task automatic test_multicycle();
    do_reset();
    mc_start_E = 1'b1;
    #1;
    total++;
    if ({a_ctl, b_ctl} !== 12'd0) begin
      bad++; $display("FAIL mc_issue got=%b exp=0", {a_ctl, b_ctl});
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      mc_start_E = (i == 3);
      branch_taken_E = (i == 2);
      mc_done = (i == 5);
      #1;
      total++;
      if ({a_ctl, b_ctl} !== {6'b111001, 6'b111001}) begin
        bad++; $display("FAIL mc_wait cyc=%0d got=%b exp=111001111001", i, {a_ctl, b_ctl});
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    total++;
    if ({a_ctl, a_mc_err, a_stall_cnt, a_flush_cnt} !== {6'd0, 1'b0, 16'd6, 16'd0}) begin
      bad++; $display("FAIL mc_done_exit got=%b/%b/%0d/%0d exp=0/0/6/0",
                      a_ctl, a_mc_err, a_stall_cnt, a_flush_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    // Completion on the final allowed cycle beats the timeout.
    mc_start_E = 1'b1;
    @(negedge clk);
    mc_start_E = 1'b0;
    repeat (7) @(negedge clk);
    mc_done = 1'b1;
    #1;
    total++;
    if (a_ctl !== 6'b111001) begin
      bad++; $display("FAIL to_last_cycle got=%b exp=111001", a_ctl);
    end
    @(negedge clk);
    mc_done = 1'b0;
    #1;
    total++;
    if ({a_ctl, a_mc_err, b_mc_err, a_stall_cnt} !== {6'd0, 2'b00, 16'd8}) begin
      bad++; $display("FAIL to_done_wins got=%b/%b%b/%0d exp=0/00/8", a_ctl, a_mc_err, b_mc_err, a_stall_cnt);
    end
    mc_start_E = 1'b1;
    @(negedge clk);
    mc_start_E = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if ({a_ctl, a_mc_err} !== {6'b111001, 1'b0}) begin
        bad++; $display("FAIL to_wait cyc=%0d got=%b/%b exp=111001/0", i, a_ctl, a_mc_err);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if ({a_ctl, b_ctl, a_mc_err, b_mc_err} !== {12'd0, 2'b11}) begin
      bad++; $display("FAIL to_expired got=%b/%b%b exp=0/11", {a_ctl, b_ctl}, a_mc_err, b_mc_err);
    end
    total++;
    if ({a_stall_cnt, b_stall_cnt} !== {16'd16, 4'd15}) begin
      bad++; $display("FAIL to_stall_cnt got=%0d/%0d exp=16/15", a_stall_cnt, b_stall_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if ({a_mc_err, b_mc_err} !== 2'b11) begin
        bad++; $display("FAIL to_sticky cyc=%0d got=%b exp=11", i, {a_mc_err, b_mc_err});
      end
    end
    @(negedge clk);
    mc_start_E = 1'b1;
    @(negedge clk);
    mc_start_E = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    total++;
    if (a_ctl !== 6'b111001) begin
      bad++; $display("FAIL to_rewait got=%b exp=111001", a_ctl);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_ctl, b_ctl, a_mc_err, b_mc_err, a_stall_cnt, b_stall_cnt} !== 34'd0) begin
      bad++; $display("FAIL to_async_reset got=%b/%b%b/%0d/%0d exp=0",
                      {a_ctl, b_ctl}, a_mc_err, b_mc_err, a_stall_cnt, b_stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({a_ctl, b_ctl} !== 12'd0) begin
      bad++; $display("FAIL to_after_reset got=%b exp=0", {a_ctl, b_ctl});
    end
  endtask

  task automatic test_random();
    bit lu, brf;
    logic [5:0] e_ctl, act_ctl;
    int e_fa, e_fb, act_fa, act_fb, act_sc, act_fc;
    bit act_err;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_ld[k] = 0; m_br[k] = 0; m_age[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      m_mc[k] = 1'b0; m_err[k] = 1'b0;
    end
    for (int n = 0; n < 1500; n++) begin
      regSrcA_D = rreg(); regSrcB_D = rreg(); regSrcA_E = rreg(); regSrcB_E = rreg();
      regScr_E = rreg(); regScr_M = rreg(); regScr_W = rreg();
      useA_D = 1'($urandom_range(0, 1)); useB_D = 1'($urandom_range(0, 1));
      regw_E = 1'($urandom_range(0, 1)); regmem_E = 1'($urandom_range(0, 1));
      regw_M = 1'($urandom_range(0, 1)); regw_W = 1'($urandom_range(0, 1));
      branch_taken_E = ($urandom_range(0, 9) == 0);
      mc_start_E = ($urandom_range(0, 11) == 0);
      mc_done = ($urandom_range(0, 5) == 0);
      #1;
      lu = regmem_E && regw_E && (regScr_E != 4'd15) &&
           ((useA_D && regSrcA_D == regScr_E) || (useB_D && regSrcB_D == regScr_E));
      e_fa = ref_fwd(regSrcA_E);
      e_fb = ref_fwd(regSrcB_E);
      for (int k = 0; k < 2; k++) begin
        brf = 1'b0;
        if (m_ld[k] > 0)            e_ctl = 6'b110010;
        else if (m_br[k] > 0)       e_ctl = 6'b000100;
        else if (m_mc[k])           e_ctl = 6'b111001;
        else if (branch_taken_E) begin e_ctl = 6'b000110; brf = 1'b1; end
        else if (mc_start_E)        e_ctl = 6'b000000;
        else if (lu)                e_ctl = 6'b110010;
        else                        e_ctl = 6'b000000;
        if (k == 0) begin
          act_ctl = a_ctl; act_fa = int'(a_fwdA); act_fb = int'(a_fwdB);
          act_err = a_mc_err; act_sc = int'(a_stall_cnt); act_fc = int'(a_flush_cnt);
        end else begin
          act_ctl = b_ctl; act_fa = int'(b_fwdA); act_fb = int'(b_fwdB);
          act_err = b_mc_err; act_sc = int'(b_stall_cnt); act_fc = int'(b_flush_cnt);
        end
        total++;
        if (act_ctl !== e_ctl) begin
          bad++; $display("FAIL rnd_ctl inst=%0d cyc=%0d got=%b exp=%b", k, n, act_ctl, e_ctl);
        end
        total++;
        if (act_fa != e_fa || act_fb != e_fb) begin
          bad++; $display("FAIL rnd_fwd inst=%0d cyc=%0d got=%0d/%0d exp=%0d/%0d", k, n, act_fa, act_fb, e_fa, e_fb);
        end
        total++;
        if (act_err !== m_err[k]) begin
          bad++; $display("FAIL rnd_mc_err inst=%0d cyc=%0d got=%b exp=%b", k, n, act_err, m_err[k]);
        end
        total++;
        if (act_sc != m_sc[k] || act_fc != m_fc[k]) begin
          bad++; $display("FAIL rnd_counters inst=%0d cyc=%0d got=%0d/%0d exp=%0d/%0d", k, n, act_sc, act_fc, m_sc[k], m_fc[k]);
        end
        // Advance the model to the state after the coming clock edge.
        if (e_ctl[4] && m_sc[k] < p_max[k]) m_sc[k]++;
        if (brf && m_fc[k] < p_max[k]) m_fc[k]++;
        if (m_ld[k] > 0) m_ld[k]--;
        else if (m_br[k] > 0) m_br[k]--;
        else if (m_mc[k]) begin
          if (mc_done) m_mc[k] = 1'b0;
          else if (m_age[k] == p_mt - 1) begin m_mc[k] = 1'b0; m_err[k] = 1'b1; end
          else m_age[k]++;
        end
        else if (branch_taken_E) m_br[k] = p_bp[k] - 1;
        else if (mc_start_E) begin m_mc[k] = 1'b1; m_age[k] = 0; end
        else if (lu) m_ld[k] = p_ll[k] - 1;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_vs_load();
    test_forwarding();
    test_multicycle();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
